// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits LSB first, runtime baud divisor,
// optional even/odd parity, 1 or 2 stop bits, valid/ready input and a tx_done pulse.
module uart_tx_cfg #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int IDX_W = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;

  logic              bit_end;

  assign bit_end = (cnt_q == div_q - DIV_W'(1));

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    shift_d   = shift_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (in_valid) begin
          state_d   = S_START;
          shift_d   = in_data;
          div_d     = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
          par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          // Odd parity (10) is the inverse of the even XOR-reduction.
          par_bit_d = (^in_data) ^ cfg_parity[1];
          stop2_d   = cfg_stop2;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d   = '0;
            state_d = par_en_q ? S_PAR : S_STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        // idx counts the stop bits already sent when two are configured.
        if (bit_end) begin
          if (stop2_q && (idx_q == '0)) begin
            idx_d = IDX_W'(1);
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: frame datapath registers are loaded on every accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    div_q     <= div_d;
    par_en_q  <= par_en_d;
    par_bit_q <= par_bit_d;
    stop2_q   <= stop2_d;
  end

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign tx_serial = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: a frame-level model expanded into a per-cycle
// line queue is compared every cycle, plus literal frame captures for directed cases.
module tb_uart_tx_cfg;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIV_W-1:0]  baud_div;
  logic [1:0]        cfg_parity;
  logic              cfg_stop2;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_serial;
  logic              tx_busy;
  logic              tx_done;

  uart_tx_cfg #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on accept, the whole frame is expanded into one expected line value per cycle.
  bit m_line = 1'b1;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_acc  = 1'b0;
  bit line_q[$];

  function automatic void build_frame();
    int d;
    bit bits[$];
    d = (baud_div < 2) ? 2 : int'(baud_div);
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(in_data[i]);
    if (cfg_parity == 2'b01) bits.push_back(^in_data);
    if (cfg_parity == 2'b10) bits.push_back(~^in_data);
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    foreach (bits[k]) for (int j = 0; j < d; j++) line_q.push_back(bits[k]);
  endfunction

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (rst) begin
      line_q.delete();
      m_line = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (!m_busy && in_valid) begin
      build_frame();
      m_line = line_q.pop_front();
      m_busy = 1'b1;
      m_done = 1'b0;
      m_acc  = 1'b1;
    end else if (m_busy) begin
      if (line_q.size() == 0) begin
        m_line = 1'b1;
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_line = line_q.pop_front();
        m_done = 1'b0;
      end
    end else begin
      m_line = 1'b1;
      m_done = 1'b0;
    end
  end

  bit           chk_en = 1'b0;
  logic [127:0] hist;
  int           busy_cnt;
  int           done_cnt;

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_serial", tx_serial, m_line);
      check("tx_busy", tx_busy, m_busy);
      check("tx_done", tx_done, m_done);
      check("in_ready", in_ready, !m_busy && !rst);
      if (tx_busy || tx_done) hist = {hist[126:0], tx_serial};
      if (tx_busy) busy_cnt++;
      if (tx_done) done_cnt++;
    end
  end

  task automatic clear_mon();
    hist     = '0;
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic wait_acc();
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (m_acc) begin
        seen = 1'b1;
        break;
      end
    end
    check("accept_seen", seen, 1'b1);
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    wait_acc();
    in_valid = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      if (!m_busy) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_end_seen", seen, 1'b1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    baud_div   = 16'd4;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    clear_mon();

    // Reset held for three edges.
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_serial", tx_serial, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // 8N1, div 4, 0xA5.
    clear_mon();
    send(8'hA5);
    wait_frame();
    check("a5_line", hist, {40'h0F0F00F0FF, 1'b1});
    check("a5_busy_cycles", busy_cnt, 40);
    check("a5_done_pulses", done_cnt, 1);

    // Even then odd parity on 0x07.
    clear_mon();
    cfg_parity = 2'b01;
    send(8'h07);
    wait_frame();
    check("even_line", hist, {44'h0FFF00000FF, 1'b1});
    check("even_busy_cycles", busy_cnt, 44);
    clear_mon();
    cfg_parity = 2'b10;
    send(8'h07);
    wait_frame();
    check("odd_line", hist, {44'h0FFF000000F, 1'b1});
    check("odd_busy_cycles", busy_cnt, 44);

    // Two stop bits, back-to-back with in_valid held.
    clear_mon();
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b1;
    in_data    = 8'h00;
    in_valid   = 1'b1;
    wait_acc();
    in_data = 8'hFF;
    wait_acc();
    in_valid = 1'b0;
    wait_frame();
    check("b2b_line", hist, {44'h000000000FF, 1'b1, 44'h0FFFFFFFFFF, 1'b1});
    check("b2b_busy_cycles", busy_cnt, 88);
    check("b2b_done_pulses", done_cnt, 2);

    // Reset pulsed during data bit 3, then a clean frame.
    cfg_stop2 = 1'b0;
    clear_mon();
    send(8'h5A);
    repeat (18) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("abort_tx_serial", tx_serial, 1'b1);
    check("abort_tx_busy", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    clear_mon();
    send(8'h3C);
    wait_frame();
    check("after_abort_line", hist, {40'h000FFFF00F, 1'b1});

    // baud_div 0 behaves as 2; config changes mid-frame are ignored.
    clear_mon();
    baud_div = 16'd0;
    send(8'h81);
    repeat (5) @(posedge clk);
    #1;
    baud_div   = 16'd6;
    cfg_parity = 2'b01;
    cfg_stop2  = 1'b1;
    wait_frame();
    check("div0_line", hist, {20'h3000F, 1'b1});
    check("div0_busy_cycles", busy_cnt, 20);
    check("div0_done_pulses", done_cnt, 1);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
